// File: rtl/axi_xbar_pkg.sv
// Shared definitions for the crossbar address-channel scheduler.
//   NUM_REQ_DEF     default number of requesters (slave ports)
//   WEIGHT_BITS_DEF default width of a per-requester weight
//   MAX_OUTST_DEF   default per-requester outstanding-transaction limit
//   sched_cfg_t     one weight-programming record {idx, weight} at default widths
package axi_xbar_pkg;

    localparam int NUM_REQ_DEF     = 5;
    localparam int WEIGHT_BITS_DEF = 4;
    localparam int MAX_OUTST_DEF   = 16;

    typedef struct packed {
        logic [$clog2(NUM_REQ_DEF)-1:0] idx;
        logic [WEIGHT_BITS_DEF-1:0]     weight;
    } sched_cfg_t;

endpackage

// File: rtl/axi_xbar_rr_pick.sv
// Combinational round-robin picker.
//   elig   in  N   per-requester eligibility
//   start  in  IW  search origin; the search order is start+1, start+2, ..., start
//   found  out 1   some requester is eligible
//   idx    out IW  first eligible index in search order (0 when none)
module axi_xbar_rr_pick #(
    parameter int N  = 5,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;

    // Bit k of rot is requester (start+1+k) mod N, so the lowest set bit wins.
    always_comb begin
        dbl   = {elig, elig};
        rot   = N'(dbl >> (int'(start) + 1));
        found = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                idx   = IW'((int'(start) + 1 + k) % N);
            end
        end
    end

endmodule

// File: rtl/axi_xbar_wrr_sched.sv
// Weighted round-robin address-channel scheduler with per-requester
// outstanding-transaction limits for one crossbar master port.
//   clk, rst                   clock, synchronous active-high reset
//   req         in  NUM_REQ    per-requester address valid
//   ready       in  1          downstream address ready
//   grant_valid out 1          a grant is presented
//   grant_i     out IDX_BITS   granted requester
//   done/done_i in  1/IDX_BITS one transaction of requester done_i completed
//   cfg_we/cfg_idx/cfg_weight  weight write port (weight 0 disables)
//   busy        out 1          some requester has transactions in flight
//   err_underflow out 1        sticky: completion seen with nothing outstanding
module axi_xbar_wrr_sched
    import axi_xbar_pkg::*;
#(
    parameter int NUM_REQ     = NUM_REQ_DEF,
    parameter int WEIGHT_BITS = WEIGHT_BITS_DEF,
    parameter int MAX_OUTST   = MAX_OUTST_DEF,
    parameter int IDX_BITS    = $clog2(NUM_REQ),
    parameter int OUT_BITS    = $clog2(MAX_OUTST + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic                   ready,
    output logic                   grant_valid,
    output logic [IDX_BITS-1:0]    grant_i,
    input  logic                   done,
    input  logic [IDX_BITS-1:0]    done_i,
    input  logic                   cfg_we,
    input  logic [IDX_BITS-1:0]    cfg_idx,
    input  logic [WEIGHT_BITS-1:0] cfg_weight,
    output logic                   busy,
    output logic                   err_underflow
);

    logic [IDX_BITS-1:0]    ptr_q, ptr_d;
    logic [WEIGHT_BITS-1:0] cnt_q, cnt_d;
    logic [WEIGHT_BITS-1:0] weight_q [NUM_REQ];
    logic [WEIGHT_BITS-1:0] weight_d [NUM_REQ];
    logic [OUT_BITS-1:0]    outst_q  [NUM_REQ];
    logic [OUT_BITS-1:0]    outst_d  [NUM_REQ];
    logic                   locked_q, locked_d;
    logic [IDX_BITS-1:0]    lock_idx_q, lock_idx_d;
    logic                   err_q, err_d;

    logic [NUM_REQ-1:0]     elig;
    logic                   ptr_turn;
    logic                   pick_found;
    logic [IDX_BITS-1:0]    pick_idx;
    logic                   accept;
    logic                   inc, dec;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req[i] && (weight_q[i] != '0) && (outst_q[i] < OUT_BITS'(MAX_OUTST));
        end
    end

    axi_xbar_rr_pick #(
        .N  (NUM_REQ),
        .IW (IDX_BITS)
    ) u_pick (
        .elig  (elig),
        .start (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // A presented grant is held through a stall even if its requester
    // drops out of eligibility, so ready never feeds back into the choice.
    always_comb begin
        ptr_turn    = elig[ptr_q] && (cnt_q < weight_q[ptr_q]);
        grant_valid = 1'b0;
        grant_i     = '0;
        if (locked_q) begin
            grant_valid = 1'b1;
            grant_i     = lock_idx_q;
        end else if (ptr_turn) begin
            grant_valid = 1'b1;
            grant_i     = ptr_q;
        end else if (pick_found) begin
            grant_valid = 1'b1;
            grant_i     = pick_idx;
        end
    end

    assign accept = grant_valid && ready;

    always_comb begin
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        locked_d   = locked_q;
        lock_idx_d = lock_idx_q;
        err_d      = err_q;
        weight_d   = weight_q;
        outst_d    = outst_q;
        inc        = 1'b0;
        dec        = 1'b0;

        if (accept) begin
            locked_d = 1'b0;
            // Staying on the turn owner spends one more of its weight; any
            // other grant starts a new turn that already used one slot.
            if (grant_i == ptr_q && cnt_q < weight_q[ptr_q]) begin
                cnt_d = cnt_q + WEIGHT_BITS'(1);
            end else begin
                ptr_d = grant_i;
                cnt_d = WEIGHT_BITS'(1);
            end
        end else if (grant_valid) begin
            locked_d   = 1'b1;
            lock_idx_d = grant_i;
        end

        for (int i = 0; i < NUM_REQ; i++) begin
            inc = accept && (grant_i == IDX_BITS'(i));
            dec = done && (done_i == IDX_BITS'(i));
            if (inc && !dec) begin
                outst_d[i] = outst_q[i] + OUT_BITS'(1);
            end else if (dec && !inc) begin
                if (outst_q[i] == '0) begin
                    err_d = 1'b1;
                end else begin
                    outst_d[i] = outst_q[i] - OUT_BITS'(1);
                end
            end
            if (cfg_we && cfg_idx == IDX_BITS'(i)) begin
                weight_d[i] = cfg_weight;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            cnt_q      <= '0;
            locked_q   <= 1'b0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                weight_q[i] <= WEIGHT_BITS'(1);
                outst_q[i]  <= '0;
            end
        end else begin
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            locked_q   <= locked_d;
            lock_idx_q <= lock_idx_d;
            err_q      <= err_d;
            weight_q   <= weight_d;
            outst_q    <= outst_d;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (outst_q[i] != '0) busy = 1'b1;
        end
    end

    assign err_underflow = err_q;

endmodule

// File: tb/tb_axi_xbar_wrr_sched.sv
// Directed bench for axi_xbar_wrr_sched: a per-cycle vector table on the
// default-parameter instance and a hand-written sequence on a second
// instance with a small outstanding limit.
module tb_axi_xbar_wrr_sched;

    logic       clk;
    logic       rst;
    logic [4:0] req;
    logic       ready;
    logic       done;
    logic [2:0] done_i;
    logic       cfg_we;
    logic [2:0] cfg_idx;
    logic [3:0] cfg_weight;

    logic       gv, bsy, err;
    logic [2:0] gi;
    logic       gv2, bsy2, err2;
    logic [2:0] gi2;

    int n_chk = 0;
    int n_err = 0;

    axi_xbar_wrr_sched dut (
        .clk(clk), .rst(rst), .req(req), .ready(ready),
        .grant_valid(gv), .grant_i(gi),
        .done(done), .done_i(done_i),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_weight(cfg_weight),
        .busy(bsy), .err_underflow(err)
    );

    axi_xbar_wrr_sched #(.MAX_OUTST(2)) dut2 (
        .clk(clk), .rst(rst), .req(req), .ready(ready),
        .grant_valid(gv2), .grant_i(gi2),
        .done(done), .done_i(done_i),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_weight(cfg_weight),
        .busy(bsy2), .err_underflow(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [4:0] req;
        logic       rdy;
        logic       dn;
        logic [2:0] di;
        logic       we;
        logic [2:0] ci;
        logic [3:0] cw;
        logic       gv;
        logic [2:0] gi;
        logic       bsy;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input int r, input int rq, input int rd, input int dn, input int di,
                        input int we, input int ci, input int cw,
                        input int egv, input int egi, input int ebsy, input int eerr);
        vec_t v;
        v.rst = r[0];  v.req = rq[4:0]; v.rdy = rd[0]; v.dn = dn[0]; v.di = di[2:0];
        v.we = we[0];  v.ci = ci[2:0];  v.cw = cw[3:0];
        v.gv = egv[0]; v.gi = egi[2:0]; v.bsy = ebsy[0]; v.err = eerr[0];
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [4:0] rq, input logic rd,
                         input logic dn, input logic [2:0] di,
                         input logic we, input logic [2:0] ci, input logic [3:0] cw);
        @(negedge clk);
        rst = r; req = rq; ready = rd; done = dn; done_i = di;
        cfg_we = we; cfg_idx = ci; cfg_weight = cw;
        #1;
    endtask

    initial begin
        rst = 1'b1; req = '0; ready = 1'b0; done = 1'b0; done_i = '0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_weight = '0;
        repeat (2) @(posedge clk);

        //   rst req      rdy dn di we ci cw   gv gi busy err
        // plain round-robin between 0 and 2
        addv(0, 5'b00101, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0);
        addv(0, 5'b00101, 1, 0, 0, 0, 0, 0,  1, 2, 1, 0);
        addv(0, 5'b00101, 1, 0, 0, 0, 0, 0,  1, 0, 1, 0);
        addv(0, 5'b00101, 1, 0, 0, 0, 0, 0,  1, 2, 1, 0);
        addv(1, 5'b00000, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0);
        addv(0, 5'b00000, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        // weight[0]=3 gives 0,0,0,1 pattern
        addv(0, 5'b00000, 0, 0, 0, 1, 0, 3,  0, 0, 0, 0);
        addv(0, 5'b00011, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0);
        addv(0, 5'b00011, 1, 0, 0, 0, 0, 0,  1, 0, 1, 0);
        addv(0, 5'b00011, 1, 0, 0, 0, 0, 0,  1, 0, 1, 0);
        addv(0, 5'b00011, 1, 0, 0, 0, 0, 0,  1, 1, 1, 0);
        addv(0, 5'b00011, 1, 0, 0, 0, 0, 0,  1, 0, 1, 0);
        addv(0, 5'b00011, 1, 0, 0, 0, 0, 0,  1, 0, 1, 0);
        addv(0, 5'b00011, 1, 0, 0, 0, 0, 0,  1, 0, 1, 0);
        addv(0, 5'b00011, 1, 0, 0, 0, 0, 0,  1, 1, 1, 0);
        addv(1, 5'b00000, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0);
        // stalled grant to 3 stays locked while 1 arrives
        addv(0, 5'b01000, 0, 0, 0, 0, 0, 0,  1, 3, 0, 0);
        addv(0, 5'b01000, 0, 0, 0, 0, 0, 0,  1, 3, 0, 0);
        addv(0, 5'b01000, 0, 0, 0, 0, 0, 0,  1, 3, 0, 0);
        addv(0, 5'b01000, 0, 0, 0, 0, 0, 0,  1, 3, 0, 0);
        addv(0, 5'b01010, 0, 0, 0, 0, 0, 0,  1, 3, 0, 0);
        addv(0, 5'b01010, 1, 0, 0, 0, 0, 0,  1, 3, 0, 0);
        addv(0, 5'b01010, 1, 0, 0, 0, 0, 0,  1, 1, 1, 0);
        addv(1, 5'b00000, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0);
        // accept+done same index nets zero; done on empty counter is sticky error
        addv(0, 5'b00100, 1, 0, 0, 0, 0, 0,  1, 2, 0, 0);
        addv(0, 5'b00100, 1, 1, 2, 0, 0, 0,  1, 2, 1, 0);
        addv(0, 5'b00000, 0, 1, 0, 0, 0, 0,  0, 0, 1, 0);
        addv(0, 5'b00000, 0, 1, 2, 0, 0, 0,  0, 0, 1, 1);
        addv(0, 5'b00000, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);
        addv(1, 5'b00000, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);
        addv(0, 5'b00000, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        // weight 0 disables, weight 2 re-enables with two-grant turns
        addv(0, 5'b00000, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0);
        addv(0, 5'b00010, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        addv(0, 5'b00010, 1, 0, 0, 1, 1, 2,  0, 0, 0, 0);
        addv(0, 5'b00010, 1, 0, 0, 0, 0, 0,  1, 1, 0, 0);
        addv(0, 5'b00010, 1, 0, 0, 0, 0, 0,  1, 1, 1, 0);
        addv(0, 5'b00010, 1, 0, 0, 0, 0, 0,  1, 1, 1, 0);
        addv(0, 5'b00010, 1, 0, 0, 1, 7, 0,  1, 1, 1, 0);
        addv(0, 5'b00010, 1, 0, 0, 0, 0, 0,  1, 1, 1, 0);
        addv(1, 5'b00000, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0);
        // weight write does not break an active lock
        addv(0, 5'b00001, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0);
        addv(0, 5'b00001, 0, 0, 0, 1, 0, 0,  1, 0, 0, 0);
        addv(0, 5'b00001, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0);
        addv(0, 5'b00001, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0);
        addv(0, 5'b00001, 1, 0, 0, 0, 0, 0,  0, 0, 1, 0);

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].rst, vecs[k].req, vecs[k].rdy, vecs[k].dn, vecs[k].di,
                  vecs[k].we, vecs[k].ci, vecs[k].cw);
            chk($sformatf("v%0d grant_valid", k), 32'(gv), 32'(vecs[k].gv));
            chk($sformatf("v%0d grant_i", k), 32'(gi), 32'(vecs[k].gi));
            chk($sformatf("v%0d busy", k), 32'(bsy), 32'(vecs[k].bsy));
            chk($sformatf("v%0d err_underflow", k), 32'(err), 32'(vecs[k].err));
        end

        // Outstanding limit of 2 on the second instance, no same-cycle bypass
        drive(1, 5'b00000, 0, 0, 0, 0, 0, 0);
        drive(0, 5'b10000, 1, 0, 0, 0, 0, 0);
        chk("lim first gv", 32'(gv2), 32'd1);
        chk("lim first gi", 32'(gi2), 32'd4);
        chk("lim first busy", 32'(bsy2), 32'd0);
        drive(0, 5'b10000, 1, 0, 0, 0, 0, 0);
        chk("lim second gv", 32'(gv2), 32'd1);
        chk("lim second gi", 32'(gi2), 32'd4);
        drive(0, 5'b10000, 1, 0, 0, 0, 0, 0);
        chk("lim full gv", 32'(gv2), 32'd0);
        chk("lim full busy", 32'(bsy2), 32'd1);
        drive(0, 5'b10000, 1, 1, 4, 0, 0, 0);
        chk("lim done no bypass", 32'(gv2), 32'd0);
        drive(0, 5'b10000, 1, 0, 0, 0, 0, 0);
        chk("lim freed gv", 32'(gv2), 32'd1);
        chk("lim freed gi", 32'(gi2), 32'd4);
        drive(0, 5'b10000, 1, 0, 0, 0, 0, 0);
        chk("lim refull gv", 32'(gv2), 32'd0);
        // reset mid-operation clears the outstanding counts
        drive(1, 5'b10000, 0, 0, 0, 0, 0, 0);
        drive(0, 5'b10000, 0, 0, 0, 0, 0, 0);
        chk("rst clears outst gv", 32'(gv2), 32'd1);
        chk("rst clears outst busy", 32'(bsy2), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/axi_xbar_wrr_sched.md
# axi_xbar_wrr_sched

Weighted round-robin scheduler with per-requester outstanding-transaction limits, driving the address-channel (AW or AR) select of one crossbar master port. It replaces the fixed 5-input arbiter: it picks which slave port owns the next address beat and holds that grant stable until accepted. It also throttles requesters that have too many transactions in flight. Weights are runtime-configurable; completions (B, or R with last) return credits.

## Interface
- `NUM_REQ`, default 5: number of requesters (slave ports).
- `WEIGHT_BITS`, default 4: width of each per-requester weight.
- `MAX_OUTST`, default 16: per-requester outstanding limit, 1..256.
- `IDX_BITS`, default `$clog2(NUM_REQ)`: width of the grant and done index.
- `OUT_BITS`, default `$clog2(MAX_OUTST+1)`: width of the outstanding counters.

Ports (clock and reset: reset `rst`, synchronous, active-high; clock `clk`):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `req`  in  NUM_REQ  per-requester address valid.
- `ready`  in  1  downstream address ready (already qualified by the caller's FIFO-full and credit checks).
- `grant_valid`  out  1  a grant is presented.
- `grant_i`  out  IDX_BITS  index of the granted requester.
- `done`  in  1  one transaction completed.
- `done_i`  in  IDX_BITS  index of the requester whose transaction completed.
- `cfg_we`  in  1  weight write strobe.
- `cfg_idx`  in  IDX_BITS  index of the weight to write.
- `cfg_weight`  in  WEIGHT_BITS  new weight; 0 disables the requester.
- `busy`  out  1  any outstanding count is non-zero.
- `err_underflow`  out  1  sticky: `done` arrived for a counter already at 0.

## Operation
- State registers:
  - `ptr`: current turn owner.
  - `cnt`: grants used in the current turn, width WEIGHT_BITS.
  - `outst[i]`: per-requester outstanding count.
  - `weight[i]`.
  - `locked` and `lock_i`.
  - `err_underflow`.
- Eligibility: `elig[i] = req[i] && weight[i]!=0 && outst[i] < MAX_OUTST`.
- Selection (combinational):
  - If `locked`: grant `lock_i`, regardless of `elig`.
  - Else if `elig[ptr] && cnt < weight[ptr]`: grant `ptr`.
  - Else: grant the first eligible index searching `ptr+1, ptr+2, …` with wrap-around, ending at `ptr` itself.
  - If no requester is eligible: `grant_valid=0` and `grant_i=0`.
- Accept, when `grant_valid && ready`:
  - If `grant_i==ptr` and `cnt<weight[ptr]`: `cnt<=cnt+1`.
  - Otherwise: `ptr<=grant_i` and `cnt<=1`.
  - `outst[grant_i]` increments; `locked<=0`.
- Stall, when `grant_valid && !ready`: `locked<=1`, `lock_i<=grant_i`. This keeps the grant stable as AXI requires.
- Completion, when `done`: `outst[done_i]` decrements.
  - Accept and done on the same index in the same cycle: net change 0.
  - Done while the counter is 0: the counter stays 0 and `err_underflow<=1`.
- Config: `cfg_we` writes `weight[cfg_idx]`, effective from the next cycle.
  - A write never breaks an active lock.
  - Lowering a weight below `cnt` ends the turn at the next selection.
  - An out-of-range `cfg_idx` is ignored.
- Reset values:
  - `ptr=0`, `cnt=0`, all `outst=0`, all `weight=1` (plain round-robin).
  - `locked=0`, `err_underflow=0`.
  - Therefore `grant_valid=0`, `grant_i=0`, `busy=0`.

## Timing
- `req` to `grant_valid`/`grant_i`: combinational, 0 cycles. No combinational path from `ready` to `grant_*`.
- State, counters and lock update on the `clk` edge after the accept, done or cfg event.
- `done` frees a slot for the next cycle's eligibility; there is no same-cycle bypass.
- Back-to-back accepts are sustained at 1 per cycle.
- `rst` asserted mid-operation clears everything in one cycle, including the outstanding counts; the caller also resets its completion path.

## Structure
- Package `axi_xbar_pkg` holds:
  - the `NUM_REQ` default;
  - the `WEIGHT_BITS` default;
  - the `MAX_OUTST` default;
  - the `sched_cfg_t` struct `{idx, weight}`.
- One sub-module, `axi_xbar_rr_pick`: a combinational rotate-and-priority-encode taking `elig` and a start index, returning `found` and `idx`.
- Counters and the lock stay in the top module.

## Test plan
- After reset, hold `req=5'b00101` with `ready=1` and all weights 1: grants alternate 0,2,0,2; `busy=1`.
- Set `weight[0]=3` and hold `req=5'b00011` with `ready=1`: sequence 0,0,0,1,0,0,0,1.
- Assert `req[3]` with `ready=0` for 4 cycles, then raise `req[1]`: `grant_i` stays 3 until `ready`; then grant 1 next cycle.
- Set `MAX_OUTST=2`, hold `req[4]` with `ready=1` and no `done`: exactly 2 grants, then `grant_valid=0`. Pulse `done` with `done_i=4`: one more grant on the following cycle.
- Hold `req[2]` with `outst[2]=1`; accept and `done_i=2` in the same cycle: `outst[2]` stays 1. Then issue `done_i=0` with `outst[0]=0`: `err_underflow=1`, held until reset.
- Write `weight[1]=0` while `req=5'b00010`: `grant_valid=0`. Write `weight[1]=2`: grants resume the next cycle.
